// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch: FSM states, BCD time word,
// digit moduli and the ripple-carry BCD increment used by the time base.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP,
    HALT
  } sw_state_e;

  localparam int unsigned NUM_DIGITS     = 6;
  localparam int unsigned MOD_HUNDREDTHS = 10;
  localparam int unsigned MOD_TENTHS     = 10;
  localparam int unsigned MOD_SEC_ONES   = 10;
  localparam int unsigned MOD_SEC_TENS   = 6;
  localparam int unsigned MOD_MIN_ONES   = 10;
  localparam int unsigned MOD_MIN_TENS   = 6;

  localparam logic [3:0]  BLANK    = 4'hF;
  localparam logic [23:0] MAX_TIME = 24'h595999;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenths;
    logic [3:0] hundredths;
  } bcd_time_t;

  // Digit index 0 is hundredths (LSB nibble), 5 is min_tens.
  function automatic int unsigned digit_mod(input int unsigned idx);
    case (idx)
      0:       return MOD_HUNDREDTHS;
      1:       return MOD_TENTHS;
      2:       return MOD_SEC_ONES;
      3:       return MOD_SEC_TENS;
      4:       return MOD_MIN_ONES;
      default: return MOD_MIN_TENS;
    endcase
  endfunction

  function automatic bcd_time_t bcd_increment(input bcd_time_t t);
    logic [23:0] v;
    logic        carry;
    v     = t;
    carry = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'(digit_mod(i) - 1)) begin
          v[4*i +: 4] = 4'd0;
        end else begin
          v[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return bcd_time_t'(v);
  endfunction

endpackage

// File: rtl/key_conditioner.sv
// Raw active-low pushbutton to single-cycle press pulse: 2-FF synchroniser,
// consecutive-sample debounce, registered falling-edge detect.
module key_conditioner #(
  parameter int DEB_CYCLES = 1
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = prev_q & ~level_q;
  end

  // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/lap_stopwatch.sv
// MM:SS.hh stopwatch with conditioned start/stop and lap/clear keys, a circular
// lap buffer with recall, and wrap-or-saturate behaviour at 59:59.99.
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter  int CLK_HZ      = 50_000_000,
  parameter  int TICK_HZ     = 100,
  parameter  int DEBOUNCE_MS = 10,
  parameter  int LAP_DEPTH   = 4,
  parameter  int WRAP        = 1,
  localparam int LW          = $clog2(LAP_DEPTH + 1)
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          start_stop_n,
  input  logic          lap_n,
  input  logic [LW-1:0] lap_sel,
  output logic [23:0]   time_bcd,
  output logic [LW-1:0] lap_count,
  output logic          running,
  output logic          overflow
);

  localparam int DIV         = CLK_HZ / TICK_HZ;
  localparam int DEB_RAW     = CLK_HZ * DEBOUNCE_MS / 1000;
  localparam int DEB_CYCLES  = (DEB_RAW < 1) ? 1 : DEB_RAW;
  localparam int PSW         = $clog2(DIV);
  localparam int PW          = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int MEM_ENTRIES = 1 << PW;

  logic           ss_evt, lap_evt;
  sw_state_e      state_q, state_d;
  logic [PSW-1:0] presc_q, presc_d;
  bcd_time_t      time_q, time_d;
  logic           overflow_q, overflow_d;
  logic           running_q, running_d;
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [LW-1:0]  count_q, count_d;
  bcd_time_t      disp_q, disp_d;
  bcd_time_t      lap_mem_q [MEM_ENTRIES];
  logic           tick, capture, clear;
  logic [PW-1:0]  rd_idx;
  int             rd_sum;

  key_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_key_ss (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_n    (start_stop_n),
    .press    (ss_evt)
  );

  key_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_key_lap (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_n    (lap_n),
    .press    (lap_evt)
  );

  // FSM, prescaler and digit chain; ss_evt takes priority over lap_evt.
  always_comb begin
    tick       = (state_q == RUN) && (presc_q == PSW'(DIV - 1));
    state_d    = state_q;
    presc_d    = presc_q;
    time_d     = time_q;
    overflow_d = overflow_q;
    capture    = 1'b0;
    clear      = 1'b0;
    case (state_q)
      IDLE: if (ss_evt) state_d = RUN;
      RUN: begin
        if (ss_evt)       state_d = STOP;
        else if (lap_evt) capture = 1'b1;
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          if (time_q == MAX_TIME) begin
            overflow_d = 1'b1;
            if (WRAP != 0) time_d  = '0;
            else           state_d = HALT;
          end else begin
            time_d = bcd_increment(time_q);
          end
        end
      end
      STOP: begin
        if (ss_evt)       state_d = RUN;
        else if (lap_evt) clear   = 1'b1;
      end
      HALT:    if (lap_evt) clear = 1'b1;
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d    = IDLE;
      presc_d    = '0;
      time_d     = '0;
      overflow_d = 1'b0;
    end
    running_d = (state_d == RUN);
  end

  always_comb begin
    wptr_d  = wptr_q;
    count_d = count_q;
    if (clear) begin
      wptr_d  = '0;
      count_d = '0;
    end else if (capture) begin
      wptr_d = (wptr_q == PW'(LAP_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      if (count_q != LW'(LAP_DEPTH)) count_d = count_q + 1'b1;
    end
  end

  // Live view shows the next time value so a tick is visible one cycle after it.
  always_comb begin
    rd_sum = int'(wptr_q) + LAP_DEPTH - int'(lap_sel);
    if (rd_sum >= LAP_DEPTH) rd_sum = rd_sum - LAP_DEPTH;
    rd_idx = PW'(rd_sum);
    if (lap_sel == '0)           disp_d = time_d;
    else if (lap_sel <= count_q) disp_d = lap_mem_q[rd_idx];
    else                         disp_d = {NUM_DIGITS{BLANK}};
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      time_q     <= '0;
      overflow_q <= 1'b0;
      running_q  <= 1'b0;
      wptr_q     <= '0;
      count_q    <= '0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      time_q     <= time_d;
      overflow_q <= overflow_d;
      running_q  <= running_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      disp_q     <= disp_d;
    end
  end

  // NOTE: the lap buffer is reset and bulk-cleared on purpose; a clear must zero every entry.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_ENTRIES; i++) lap_mem_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < MEM_ENTRIES; i++) lap_mem_q[i] <= '0;
    end else if (capture) begin
      lap_mem_q[wptr_q] <= time_q;
    end
  end

  assign time_bcd  = disp_q;
  assign lap_count = count_q;
  assign running   = running_q;
  assign overflow  = overflow_q;

endmodule
